conv_result_monitor: RTL and testbench
======================================

# conv_result_monitor

Parametrised on-board test sequencer and result monitor for a convolution layer, successor to the fixed six-LED Conv2 bring-up harness. It synchronises the start switch and issues a one-cycle start pulse to the layer's memory controller. It then counts the result stream per output filter, records per-filter hit counts against a programmable threshold, detects a stalled pipeline with a watchdog, and drives status LEDs. It sits between the Conv_Layer result output and the board switches/LEDs, in the `clk_x5` domain.

## Interface
- `DATA_W`, 8: result width, unsigned post-ReLU.
- `OUT_W`, 10: output feature-map width.
- `OUT_H`, 10: output feature-map height.
- `N_FILTER`, 16: number of output filters, streamed filter-major.
- `N_LED`, 6: LED count; must be ≤ `N_FILTER`.
- `THRESHOLD`, 1: a result counts as a hit when `res_data >= THRESHOLD`.
- `TIMEOUT`, 100000: idle cycles in RUN before the watchdog fires.

Ports:
- `clk_x5`, input, 1: the single clock.
- `rstn`, input, 1: asynchronous, active-low reset.
- `sw_start`, input, 1: raw board switch, asynchronous to `clk_x5`.
- `run_start`, output, 1: one-cycle start pulse to the memory controller.
- `res_valid`, input, 1: result strobe from the conv layer.
- `res_data`, input, `DATA_W`: result value.
- `rd_filter`, input, `$clog2(N_FILTER)`: hit-count read index.
- `rd_hits`, output, `HIT_W = $clog2(OUT_W*OUT_H+1)`: hit count of `rd_filter`.
- `busy`, output, 1: high in START and RUN.
- `done`, output, 1: high in DONE.
- `timeout`, output, 1: high in TIMEOUT.
- `led`, output, `N_LED`: status LEDs.

## Operation
- States and transitions:
  - IDLE → START on a synchronised rising edge of `sw_start`.
  - START → RUN after one cycle.
  - RUN → DONE on acceptance of the last pixel of the last filter.
  - RUN → TIMEOUT when the watchdog reaches `TIMEOUT`.
  - DONE or TIMEOUT → START on the next rising edge of `sw_start`.
- START, for one cycle:
  - `run_start`=1.
  - Clears `pix_cnt`, `filt_cnt`, all hit counters and the watchdog.
- RUN, on each `res_valid`:
  - `pix_cnt` increments.
  - If `res_data >= THRESHOLD` (unsigned compare), `hits[filt_cnt]` increments.
  - When `pix_cnt == OUT_W*OUT_H-1`, `pix_cnt` wraps to 0 and `filt_cnt` increments.
  - Hit counters cannot overflow; their width covers a full map.
- Ignored inputs:
  - `res_valid` outside RUN.
  - A `sw_start` rising edge in START or RUN; a run is never restarted mid-flight.
- Watchdog:
  - Counts RUN cycles since START or since the last `res_valid`.
  - `res_valid` resets it to 0.
  - If `res_valid` arrives in the cycle the count would reach `TIMEOUT`, `res_valid` wins and no timeout occurs.
- LEDs:
  - DONE: `led[i] = (hits[i] != 0)` for i < `N_LED`.
  - TIMEOUT: `led` = low `N_LED` bits of `filt_cnt`, showing the filter that stalled.
  - All other states: `led` = 0.
- `rd_hits` is readable in any state and holds its values after DONE and TIMEOUT.

## Timing
- All outputs are 0 after reset, and the state is IDLE.
- `sw_start` passes a 2-FF synchroniser plus an edge register. `run_start` pulses exactly 4 cycles after the first `clk_x5` edge that samples the switch high.
- `done` rises 1 cycle after the final `res_valid`.
- `timeout` rises `TIMEOUT` cycles after the last `res_valid`, or after START if none arrived.
- `rd_hits` is registered: 1-cycle latency from `rd_filter`.
- `led` is registered and updates in the same cycle `done` or `timeout` rises.
- Reset mid-run returns to IDLE immediately. No `run_start` is generated until a fresh switch edge, so a switch held high through reset does not start a run.

## Configuration
- `CONV_MON_CHECKSUM_EN` defined:
  - Adds output `checksum` [31:0], the sum of every accepted `res_data`, modulo 2^32.
  - Cleared in START, held in DONE and TIMEOUT, 0 at reset.
- `CONV_MON_CHECKSUM_EN` undefined: the port and its logic are absent.

## Structure
- Package `conv_mon_pkg` holds:
  - the state enum `conv_mon_state_e` (IDLE, START, RUN, DONE, TIMEOUT);
  - the `HIT_W` width helper.
- Sub-module `sync_edge_detect` implements the 2-FF synchroniser and the rising-edge pulse. It is reusable for the other board switches.

## Test plan
- Reset with `sw_start` held high, then keep it high → no `run_start`, state IDLE, all outputs 0.
- Switch rises → `run_start` pulses once 4 cycles later. Then stream 1600 results with every value = 5 → `done`=1 one cycle after the last, every `rd_hits` = 100, `led` = 6'b111111.
- Filter 2 results all 0, every other result = 1 → `rd_hits` for filter 2 = 0, `led` = 6'b111011. Also, `res_data` = `THRESHOLD`-1 is not counted and `THRESHOLD` is counted.
- Stop after 250 results with `TIMEOUT` = 50 → `timeout` rises 50 cycles after the last valid, `led` = 6'd2. A valid landing on cycle 50 keeps the monitor in RUN.
- Switch toggled again during RUN → ignored. Toggled after DONE → counters cleared and a new run completes. With the macro defined, `checksum` = 8000 for the all-5 run.
- `rstn` asserted mid-RUN → IDLE, `led`/`busy`/`done` = 0. The next run matches a fresh run.

Source files
------------

// File: rtl/conv_mon_pkg.sv
// Shared types and width helpers for the conv result monitor.
// Optional checksum output is enabled by CONV_MON_CHECKSUM_EN.
package conv_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RUN,
      ST_DONE,
      ST_TIMEOUT
   } conv_mon_state_e;

   function automatic int hit_w(input int w, input int h);
      return $clog2(w * h + 1);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with a registered rising-edge pulse.
// Reset value of 1 means a level held through reset is not an edge.
module sync_edge_detect #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic rise
);

   logic s1_q, s2_q, s3_q, rise_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q   <= RST_VAL;
         s2_q   <= RST_VAL;
         s3_q   <= RST_VAL;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= din;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         rise_q <= s2_q & ~s3_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/conv_result_monitor.sv
// Start sequencer, per-filter hit counter, watchdog and LED status for Conv_Layer.
// Define CONV_MON_CHECKSUM_EN to add the 32-bit result checksum output.
module conv_result_monitor
   import conv_mon_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int OUT_W     = 10,
   parameter int OUT_H     = 10,
   parameter int N_FILTER  = 16,
   parameter int N_LED     = 6,
   parameter int THRESHOLD = 1,
   parameter int TIMEOUT   = 100000,
   localparam int FW       = $clog2(N_FILTER),
   localparam int HIT_W    = hit_w(OUT_W, OUT_H)
) (
   input  logic              clk_x5,
   input  logic              rstn,
   input  logic              sw_start,
   output logic              run_start,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   input  logic [FW-1:0]     rd_filter,
   output logic [HIT_W-1:0]  rd_hits,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [N_LED-1:0]  led
`ifdef CONV_MON_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);

   localparam int PIX = OUT_W * OUT_H;
   localparam int PW  = $clog2(PIX);
   localparam int WW  = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0]     PIX_LAST  = PW'(PIX - 1);
   localparam logic [FW-1:0]     FILT_LAST = FW'(N_FILTER - 1);
   localparam logic [WW-1:0]     WD_LAST   = WW'(TIMEOUT - 1);
   localparam logic [DATA_W-1:0] THR       = DATA_W'(THRESHOLD);

   conv_mon_state_e state_q, state_n;
   logic [PW-1:0]    pix_q;
   logic [FW-1:0]    filt_q;
   logic [WW-1:0]    wd_q;
   logic [HIT_W-1:0] hits_q [N_FILTER];
   logic [HIT_W-1:0] rd_hits_q;
   logic [N_LED-1:0] led_q, led_n;
   logic             run_start_q;
   logic             sw_rise, accept, hit, last;
   logic [N_LED+FW-1:0] filt_ext;

   sync_edge_detect #(.RST_VAL(1'b1)) u_sw_sync (
      .clk  (clk_x5),
      .rstn (rstn),
      .din  (sw_start),
      .rise (sw_rise)
   );

   assign accept = (state_q == ST_RUN) && res_valid;
   assign hit    = accept && (res_data >= THR);
   assign last   = accept && (pix_q == PIX_LAST) && (filt_q == FILT_LAST);
   assign filt_ext = {{N_LED{1'b0}}, filt_q};

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_TIMEOUT: if (sw_rise) state_n = ST_START;
         ST_START: state_n = ST_RUN;
         ST_RUN: begin
            if (last) state_n = ST_DONE;
            else if (!res_valid && wd_q == WD_LAST) state_n = ST_TIMEOUT;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // LEDs follow the next state so they change on the same edge as done/timeout
   always_comb begin
      led_n = '0;
      unique case (1'b1)
         (state_n == ST_DONE): begin
            for (int i = 0; i < N_LED; i++)
               led_n[i] = (hits_q[i] != '0) || (hit && filt_q == FW'(i));
         end
         (state_n == ST_TIMEOUT): led_n = filt_ext[N_LED-1:0];
         default: led_n = '0;
      endcase
   end

   always_ff @(posedge clk_x5 or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         pix_q       <= '0;
         filt_q      <= '0;
         wd_q        <= '0;
         led_q       <= '0;
         rd_hits_q   <= '0;
         run_start_q <= 1'b0;
         for (int i = 0; i < N_FILTER; i++) hits_q[i] <= '0;
      end else begin
         state_q     <= state_n;
         led_q       <= led_n;
         rd_hits_q   <= hits_q[rd_filter];
         run_start_q <= (state_q == ST_START);
         if (state_q == ST_START) begin
            pix_q  <= '0;
            filt_q <= '0;
            wd_q   <= '0;
            for (int i = 0; i < N_FILTER; i++) hits_q[i] <= '0;
         end else if (state_q == ST_RUN) begin
            if (res_valid) begin
               wd_q <= '0;
               if (pix_q == PIX_LAST) begin
                  pix_q  <= '0;
                  filt_q <= filt_q + 1'b1;
               end else begin
                  pix_q <= pix_q + 1'b1;
               end
               if (hit) hits_q[filt_q] <= hits_q[filt_q] + 1'b1;
            end else begin
               wd_q <= wd_q + 1'b1;
            end
         end
      end
   end

`ifdef CONV_MON_CHECKSUM_EN
   logic [31:0] csum_q;

   always_ff @(posedge clk_x5 or negedge rstn) begin
      if (!rstn) csum_q <= '0;
      else if (state_q == ST_START) csum_q <= '0;
      else if (accept) csum_q <= csum_q + 32'(res_data);
   end

   assign checksum = csum_q;
`endif

   assign run_start = run_start_q;
   assign rd_hits   = rd_hits_q;
   assign led       = led_q;
   assign busy      = (state_q == ST_START) || (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign timeout   = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_conv_result_monitor.sv
// Directed bench for conv_result_monitor with a short watchdog.
// Checks the checksum too when CONV_MON_CHECKSUM_EN is defined.
module tb_conv_result_monitor;

   logic       clk_x5 = 1'b0;
   logic       rstn;
   logic       sw_start;
   logic       run_start;
   logic       res_valid;
   logic [7:0] res_data;
   logic [3:0] rd_filter;
   logic [6:0] rd_hits;
   logic       busy, done, timeout;
   logic [5:0] led;
`ifdef CONV_MON_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_x5 = ~clk_x5;

   conv_result_monitor #(
      .DATA_W(8), .OUT_W(10), .OUT_H(10), .N_FILTER(16),
      .N_LED(6), .THRESHOLD(1), .TIMEOUT(50)
   ) dut (
      .clk_x5    (clk_x5),
      .rstn      (rstn),
      .sw_start  (sw_start),
      .run_start (run_start),
      .res_valid (res_valid),
      .res_data  (res_data),
      .rd_filter (rd_filter),
      .rd_hits   (rd_hits),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .led       (led)
`ifdef CONV_MON_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_x5);
      #1;
   endtask

   function automatic logic [7:0] val(input int i, input int mode);
      if (mode == 0) return 8'd5;
      return (i / 100 == 2) ? 8'd0 : 8'd1;
   endfunction

   task automatic press(input string tag);
      int first;
      int pulses;
      first = -1;
      pulses = 0;
      sw_start = 1'b0;
      repeat (4) tick;
      sw_start = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick;
         if (run_start) begin
            pulses++;
            if (first < 0) first = c;
         end
      end
      check({tag, "_pulse_cycle"}, first, 4);
      check({tag, "_pulse_count"}, pulses, 1);
      check({tag, "_busy"}, busy, 1);
   endtask

   task automatic stream(input int n, input int mode, input bit toggle,
                         output int rs, output logic early);
      rs = 0;
      early = 1'b0;
      for (int i = 0; i < n; i++) begin
         res_valid = 1'b1;
         res_data  = val(i, mode);
         if (toggle && i == 500) sw_start = 1'b0;
         if (toggle && i == 510) sw_start = 1'b1;
         tick;
         if (run_start) rs++;
         if (i == n - 2) early = done;
      end
      res_valid = 1'b0;
      res_data  = '0;
   endtask

   task automatic read_hits(input int f, output int h);
      rd_filter = 4'(f);
      tick;
      h = int'(rd_hits);
   endtask

   task automatic wait_timeout(input string tag);
      int first;
      first = -1;
      for (int c = 1; c <= 60 && first < 0; c++) begin
         tick;
         if (timeout) first = c;
      end
      check({tag, "_timeout_cycle"}, first, 50);
   endtask

   initial begin
      int rs;
      int h;
      int pulses;
      logic early;

      rstn      = 1'b0;
      sw_start  = 1'b1;
      res_valid = 1'b0;
      res_data  = '0;
      rd_filter = '0;
      repeat (3) tick;
      rstn = 1'b1;
      pulses = 0;
      repeat (10) begin
         tick;
         if (run_start) pulses++;
      end
      check("rst_no_start", pulses, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_led", led, 0);
      check("rst_rd_hits", rd_hits, 0);

      press("run1");
      stream(1600, 0, 1'b1, rs, early);
      check("run1_ignored_sw", rs, 0);
      check("run1_done_early", early, 0);
      check("run1_done", done, 1);
      check("run1_busy", busy, 0);
      check("run1_led", led, 6'b111111);
      for (int f = 0; f < 16; f++) begin
         read_hits(f, h);
         check($sformatf("run1_hits%0d", f), h, 100);
      end
`ifdef CONV_MON_CHECKSUM_EN
      check("run1_checksum", checksum, 8000);
`endif

      press("run2");
      read_hits(0, h);
      check("run2_cleared", h, 0);
      stream(1600, 1, 1'b0, rs, early);
      check("run2_done", done, 1);
      check("run2_led", led, 6'b111011);
      read_hits(2, h);
      check("run2_hits2", h, 0);
      read_hits(0, h);
      check("run2_hits0", h, 100);
      read_hits(5, h);
      check("run2_hits5", h, 100);
`ifdef CONV_MON_CHECKSUM_EN
      check("run2_checksum", checksum, 1500);
`endif

      press("run3");
      stream(250, 0, 1'b0, rs, early);
      check("run3_busy", busy, 1);
      wait_timeout("run3");
      check("run3_led", led, 6'd2);
      check("run3_busy_after", busy, 0);
      check("run3_done", done, 0);
      read_hits(2, h);
      check("run3_hits2", h, 50);
      read_hits(1, h);
      check("run3_hits1", h, 100);
      read_hits(3, h);
      check("run3_hits3", h, 0);

      press("run4");
      stream(10, 0, 1'b0, rs, early);
      repeat (49) tick;
      res_valid = 1'b1;
      res_data  = 8'd5;
      tick;
      res_valid = 1'b0;
      res_data  = '0;
      check("run4_edge_busy", busy, 1);
      check("run4_edge_timeout", timeout, 0);
      wait_timeout("run4");
      check("run4_led", led, 6'd0);
      read_hits(0, h);
      check("run4_hits0", h, 11);

      press("run5");
      stream(300, 0, 1'b0, rs, early);
      rstn = 1'b0;
      #1;
      check("midrst_led", led, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_rd_hits", rd_hits, 0);
      tick;
      rstn = 1'b1;
      tick;
      check("midrst_idle_busy", busy, 0);
      press("run6");
      stream(1600, 0, 1'b0, rs, early);
      check("run6_done", done, 1);
      check("run6_led", led, 6'b111111);
      read_hits(0, h);
      check("run6_hits0", h, 100);
      read_hits(15, h);
      check("run6_hits15", h, 100);
`ifdef CONV_MON_CHECKSUM_EN
      check("run6_checksum", checksum, 8000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
